// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: pairs accepted upstream pixels with kernel taps and streams
// registered IMap/IWeight beats to one PE. Optional abort input: PE_FEEDER_ABORT_EN.
module pe_stream_feeder #(
    parameter int DATA_SIZE = 8,
    parameter int CALCYCLE  = 25,
    parameter int WIN_W     = 10
) (
    input  logic                 clk_cal,
    input  logic                 rst_cal,
    input  logic                 w_wr_en,
    input  logic [4:0]           w_wr_addr,
    input  logic [DATA_SIZE-1:0] w_wr_data,
    input  logic                 bias_wr_en,
    input  logic [DATA_SIZE-1:0] bias_wr_data,
    input  logic                 start,
`ifdef PE_FEEDER_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [WIN_W-1:0]     win_count,
    input  logic [DATA_SIZE-1:0] map_in,
    input  logic                 map_in_vld,
    output logic                 map_in_rdy,
    output logic [DATA_SIZE-1:0] IMap,
    output logic [DATA_SIZE-1:0] IWeight,
    output logic                 ImapVld,
    output logic                 IweightVld,
    output logic [DATA_SIZE-1:0] bias,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_TAP = 5'(CALCYCLE - 1);

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] kernel_q [CALCYCLE];
    logic [DATA_SIZE-1:0] bias_q;
    logic [4:0]           tap_q, tap_d;
    logic [WIN_W-1:0]     win_left_q, win_left_d;
    logic [DATA_SIZE-1:0] imap_q, imap_d;
    logic [DATA_SIZE-1:0] iweight_q, iweight_d;
    logic                 vld_q, vld_d;
    logic                 abort_w;
    logic                 accept;
    logic                 wr_tap;
    logic                 wr_bias;

`ifdef PE_FEEDER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Abort takes priority over a pixel offered on the same edge.
    assign accept  = map_in_vld && (state_q == S_RUN) && !abort_w;
    assign wr_tap  = w_wr_en && (state_q == S_IDLE) && (w_wr_addr <= LAST_TAP);
    assign wr_bias = bias_wr_en && (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        win_left_d = win_left_q;
        imap_d     = imap_q;
        iweight_d  = iweight_q;
        vld_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (win_count != '0) begin
                        state_d    = S_RUN;
                        win_left_d = win_count;
                        tap_d      = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort_w) begin
                    state_d    = S_IDLE;
                    tap_d      = '0;
                    win_left_d = '0;
                end else if (accept) begin
                    imap_d    = map_in;
                    iweight_d = kernel_q[tap_q];
                    vld_d     = 1'b1;
                    if (tap_q == LAST_TAP) begin
                        tap_d      = '0;
                        win_left_d = win_left_q - 1'b1;
                        if (win_left_q == WIN_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            win_left_q <= '0;
            imap_q     <= '0;
            iweight_q  <= '0;
            vld_q      <= 1'b0;
            bias_q     <= '0;
            for (int unsigned i = 0; i < unsigned'(CALCYCLE); i++) begin
                kernel_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            win_left_q <= win_left_d;
            imap_q     <= imap_d;
            iweight_q  <= iweight_d;
            vld_q      <= vld_d;
            if (wr_tap) begin
                kernel_q[w_wr_addr] <= w_wr_data;
            end
            if (wr_bias) begin
                bias_q <= bias_wr_data;
            end
        end
    end

    assign map_in_rdy = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign IMap       = imap_q;
    assign IWeight    = iweight_q;
    assign ImapVld    = vld_q;
    assign IweightVld = vld_q;
    assign bias       = bias_q;

endmodule

// File: doc/pe_stream_feeder.md
# pe_stream_feeder

Transmit-side driver for one LeNet convolution processing element. It holds one K*K kernel (CALCYCLE taps) and a bias, and accepts input-map pixels from the upstream line buffer over a valid/ready handshake. Each accepted pixel is paired with the matching kernel tap and emitted as a registered IMap/IWeight/valid beat on the PE input port. It counts taps and windows, so the downstream PE sees exactly CALCYCLE valid beats per output pixel, and it signals completion after a programmed number of windows.

## Interface
Parameters:
- DATA_SIZE, 8, width of map, weight and bias words
- CALCYCLE, 25, taps per window (K*K*IChannel); must match the PE's CALCYCLE
- WIN_W, 10, width of window-count field

Ports:
- clk_cal  in  1  clock, all state on rising edge
- rst_cal  in  1  reset, asynchronous, active-high
- w_wr_en  in  1  kernel tap write strobe
- w_wr_addr  in  5  tap index 0..CALCYCLE-1
- w_wr_data  in  DATA_SIZE  tap value
- bias_wr_en  in  1  bias write strobe
- bias_wr_data  in  DATA_SIZE  bias value
- start  in  1  single-cycle job start
- win_count  in  WIN_W  windows in this job, sampled on accepted start
- map_in  in  DATA_SIZE  upstream pixel
- map_in_vld  in  1  upstream pixel valid
- map_in_rdy  out  1  feeder can accept a pixel
- IMap  out  DATA_SIZE  pixel to PE
- IWeight  out  DATA_SIZE  tap to PE
- ImapVld  out  1  IMap valid
- IweightVld  out  1  IWeight valid; always equal to ImapVld
- bias  out  DATA_SIZE  bias to PE, held stable
- busy  out  1  state is RUN
- done  out  1  one-cycle job-complete pulse

## Operation
- Kernel storage: CALCYCLE x DATA_SIZE register file. Writes are accepted only in IDLE. Writes with w_wr_addr >= CALCYCLE are ignored. Writes outside IDLE are ignored.
- bias register: written only in IDLE, and drives the bias output directly.
- FSM states and transitions:
  - IDLE -> RUN on start when win_count != 0. This loads win_left = win_count and clears tap = 0.
  - IDLE -> DONE on start when win_count == 0. No beats are emitted.
  - RUN -> DONE when a pixel is accepted at tap == CALCYCLE-1 with win_left == 1.
  - DONE -> IDLE unconditionally after 1 cycle.
  - start is ignored outside IDLE.
- map_in_rdy = (state == RUN). This is combinational from state only.
- A pixel is accepted when map_in_vld & map_in_rdy. On each accept:
  - IMap <= map_in
  - IWeight <= kernel[tap]
  - ImapVld <= 1, IweightVld <= 1
  - tap increments. When tap == CALCYCLE-1 it wraps to 0 and win_left decrements.
- Cycles with no accept drive ImapVld = IweightVld = 0. IMap and IWeight hold their last values. The PE counts only valid beats, so gaps are legal.
- done = (state == DONE).
- busy = (state == RUN).

## Timing
- Reset values: map_in_rdy 0, IMap 0, IWeight 0, ImapVld 0, IweightVld 0, bias 0, busy 0, done 0, state IDLE, tap 0, win_left 0, all kernel taps 0.
- Latency is 1 cycle from an accepting edge to the corresponding valid beat. The peak rate is 1 beat per cycle.
- Last beat: the final beat's valid cycle is the same cycle done is high. map_in_rdy is already 0 in that cycle.
- Start behaviour:
  - The first accept can occur in the cycle after start.
  - start issued in the DONE cycle is ignored.
  - start issued in the following IDLE cycle is accepted.
- Reset asserted mid-job: everything returns to reset values immediately, including the kernel and bias. The PE must be reset together with the feeder.
- Simultaneous w_wr_en and start in IDLE: the write takes effect and the new job uses the written value.

## Configuration
- PE_FEEDER_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort high in RUN forces a transition to IDLE on the next edge. That edge accepts no pixel, zeroes ImapVld/IweightVld, clears tap and win_left, and produces no done pulse.
  - Kernel and bias are retained.
  - abort outside RUN has no effect.
- PE_FEEDER_ABORT_EN undefined: no abort port exists and a job runs until DONE or reset.

## Test plan
- Load taps kernel[i] = i+1 (i = 0..24), bias = 8'h05, win_count = 1, map_in_vld held 1 with map_in = 8'h02. Required: 25 consecutive beats with IWeight 1..25 and IMap 2; done high coincident with beat 25; map_in_rdy low from then on.
- Same kernel, win_count = 3, map_in_vld toggling 1,0,1,0... Required: 75 beats with a gap after every beat; IWeight sequence restarts at 1 after each 25th beat; a single done pulse after the 75th beat.
- Start with win_count = 0. Required: done pulses in the cycle after start, with no ImapVld beat and map_in_rdy never high.
- Write w_wr_addr = 3 with data 8'hFF during RUN, plus an address 27 write in IDLE. Required: both writes ignored; next job emits IWeight 4 at tap 3.
- Assert rst_cal at beat 10 of a 2-window job. Required: all outputs 0 in the same cycle; after release, a new start with reloaded taps emits tap 0 first.
- With PE_FEEDER_ABORT_EN defined, pulse abort at beat 12. Required: no further beats, no done pulse, busy low next cycle; a following start restarts at tap 0 with the kernel intact.
